// File: rtl/mux_result_unpacker.sv
// rtl/mux_result_unpacker.sv - FIFO-buffered decoder for muxed adder/comparator result words
// Optional MUX_UNPACK_STATS_EN adds saturating per-type pop counters.
module mux_result_unpacker #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [2:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_is_cmp,
  output logic [1:0]       out_sum,
  output logic             out_cout,
  output logic             out_gt,
  output logic             out_eq,
  output logic             out_lt,
  input  logic             clr_err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] sum_cnt,
  output logic [CNT_W-1:0] cmp_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [3:0]    head;
  logic          push;
  logic          pop;
  logic          in_onehot;

  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign head      = mem[rd_ptr];
  assign in_onehot = (in_data == 3'b001) || (in_data == 3'b010) || (in_data == 3'b100);

  // Storage carries no reset: contents are don't-care while count is zero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_sel, in_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // A malformed code on the same edge as clr_err must leave the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sticky <= 1'b0;
    end else if (push && in_sel && !in_onehot) begin
      err_sticky <= 1'b1;
    end else if (clr_err) begin
      err_sticky <= 1'b0;
    end
  end

  assign out_is_cmp = out_valid && head[3];
  assign out_cout   = out_valid && !head[3] && head[2];
  assign out_sum    = (out_valid && !head[3]) ? head[1:0] : 2'b00;
  assign out_gt     = out_is_cmp && head[2];
  assign out_eq     = out_is_cmp && head[1];
  assign out_lt     = out_is_cmp && head[0];

`ifdef MUX_UNPACK_STATS_EN
  logic [CNT_W-1:0] sum_cnt_q;
  logic [CNT_W-1:0] cmp_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_cnt_q <= '0;
      cmp_cnt_q <= '0;
    end else if (pop) begin
      if (!head[3] && (sum_cnt_q != '1)) begin
        sum_cnt_q <= sum_cnt_q + CNT_W'(1);
      end
      if (head[3] && (cmp_cnt_q != '1)) begin
        cmp_cnt_q <= cmp_cnt_q + CNT_W'(1);
      end
    end
  end

  assign sum_cnt = sum_cnt_q;
  assign cmp_cnt = cmp_cnt_q;
`else
  assign sum_cnt = '0;
  assign cmp_cnt = '0;
`endif

endmodule
